mxbus_rd_arbiter: RTL

- Two-master, one-slave MX bus read arbiter.
- Lets the mx11su instruction-fetch port (m0) and data-read port (m1) share a single mxbus_ram read port, for a unified-memory build.
- Sequences one read transaction at a time, with round-robin or fixed-priority grant.
- A timeout watchdog returns an error response if the slave never completes.

---
 rtl/mxbus_rd_if.sv | 23 ++
 rtl/mxbus_rd_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/mxbus_rd_if.sv
// mxbus_rd_if: one MX bus read port (request/address out, ack/ready/data/cpl back)
// Signals:
//   txn_start  request, held by the master until txn_ack
//   addr       read address, held alongside txn_start
//   txn_ack    1-cycle accept pulse
//   ready      qualifies data
//   data       read data
//   txn_cpl    1-cycle completion pulse, with or after the last ready
// Modports: master issues requests, slave answers them.
interface mxbus_rd_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  txn_start;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  txn_ack;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  txn_cpl;

    modport master (output txn_start, addr, input txn_ack, ready, data, txn_cpl);
    modport slave  (input txn_start, addr, output txn_ack, ready, data, txn_cpl);
endinterface

// File: rtl/mxbus_rd_arbiter.sv
// mxbus_rd_arbiter: two-master, one-slave MX bus read arbiter with timeout watchdog
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-low reset
//   m0, m1       master-facing read ports (instruction fetch, data read)
//   s0           slave-facing read port (shared RAM)
//   grant        one-hot owner: bit0 = m0, bit1 = m1
//   timeout_err  sticky, set on any watchdog expiry, cleared only by reset
module mxbus_rd_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    mxbus_rd_if.slave        m0,
    mxbus_rd_if.slave        m1,
    mxbus_rd_if.master       s0,
    output logic [1:0]       grant,
    output logic             timeout_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic                  last_grant;
    logic                  s_start;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  busy;
    logic                  expire;
    logic                  pick1;
    logic                  ack_v;
    logic                  rdy_v;
    logic                  cpl_v;
    logic [DATA_WIDTH-1:0] data_v;

    assign busy   = state == REQ || state == DATA;
    // a slave cpl in the expiry cycle wins over the watchdog
    assign expire = TIMEOUT_CYCLES != 0 && busy && cnt == LAST && !s0.txn_cpl;
    // last_grant: 0 = m0, 1 = m1; m1 wins a tie only in round-robin after an m0 turn
    assign pick1  = m1.txn_start && (!m0.txn_start || (FIXED_PRIORITY == 0 && !last_grant));

    // on expiry the arbiter fabricates the response itself
    always_comb begin
        ack_v  = expire ? state == REQ : state == REQ && s0.txn_ack;
        rdy_v  = expire || s0.ready;
        cpl_v  = expire || s0.txn_cpl;
        data_v = expire ? '1 : s0.data;
    end

    // grant is zero outside REQ/DATA, so FLUSH and IDLE forward nothing
    assign m0.txn_ack = grant[0] && ack_v;
    assign m0.ready   = grant[0] && rdy_v;
    assign m0.data    = grant[0] ? data_v : '0;
    assign m0.txn_cpl = grant[0] && cpl_v;
    assign m1.txn_ack = grant[1] && ack_v;
    assign m1.ready   = grant[1] && rdy_v;
    assign m1.data    = grant[1] ? data_v : '0;
    assign m1.txn_cpl = grant[1] && cpl_v;

    assign s0.txn_start = s_start;
    assign s0.addr      = s_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            s_start     <= 1'b0;
            s_addr      <= '0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.txn_start || m1.txn_start) begin
                        grant   <= pick1 ? 2'b10 : 2'b01;
                        s_addr  <= pick1 ? m1.addr : m0.addr;
                        s_start <= 1'b1;
                        cnt     <= '0;
                        state   <= REQ;
                    end
                end
                REQ, DATA: begin
                    cnt <= cnt + 1'b1;
                    if (state == REQ && s0.txn_ack) begin
                        s_start <= 1'b0;
                        state   <= DATA;
                    end
                    if (s0.txn_cpl || expire) begin
                        last_grant <= grant[1];
                        grant      <= '0;
                        s_start    <= 1'b0;
                        cnt        <= '0;
                        state      <= expire ? FLUSH : IDLE;
                    end
                    if (expire) timeout_err <= 1'b1;
                end
                default: begin
                    // FLUSH: swallow the abandoned transaction's late response
                    cnt <= cnt + 1'b1;
                    if (s0.txn_cpl || cnt == LAST) state <= IDLE;
                end
            endcase
        end
    end
endmodule
